// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32I funct3 width codes, and access legality checks.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only exist for loads; 011/110/111 are never legal.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables and replicated store
// data toward the bus, and sign/zero-extended load data back to the core.
// Purely combinational; driven from the captured request registers.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store enables and lane replication; loads always enable the full word.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (we_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_o    = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be_o    = off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

  // Pick the addressed byte/half from the response word and extend it.
  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_o = {24'd0, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_o = {16'd0, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one core load/store into a single
// word-aligned request/grant/response bus transaction, stalls the core until
// it completes, and returns formatted load data.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses instead of silently aligning them.
//
// state | meaning
// IDLE  | waiting for req_i; legality checked, request captured
// ISSUE | mem_req_o high, waiting for mem_gnt_i
// WAIT  | waiting for mem_rvalid_i, bounded by TIMEOUT_CYCLES
// RESP  | one-cycle done_o (and err_o if flagged)
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic        we_q, err_q;
  logic [7:0]  cnt_q;
  logic        access_ok;
  logic        wait_expired;
  logic [3:0]  be_w;
  logic [31:0] wdata_w, rdata_fmt;

`ifdef LSU_MISALIGN_TRAP_EN
  assign access_ok = f3_legal(we_i, funct3_i) && !is_misaligned(funct3_i, addr_i[1:0]);
`else
  assign access_ok = f3_legal(we_i, funct3_i);
`endif

  assign wait_expired = (cnt_q == TO_LAST);

  lsu_align u_align (
    .we_i     (we_q),
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata_i),
    .be_o     (be_w),
    .wdata_o  (wdata_w),
    .rdata_o  (rdata_fmt)
  );

  // State register; reset drops mem_req_o asynchronously through the decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; illegal accesses skip the bus entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_i) state_d = access_ok ? ISSUE : RESP;
      ISSUE: if (mem_gnt_i) state_d = WAIT;
      WAIT:  if (mem_rvalid_i || wait_expired) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, response timeout counter, error flag and load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            f3_q    <= funct3_i;
            we_q    <= we_i;
            err_q   <= ~access_ok;
            if (!access_ok) rdata_q <= '0;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rvalid_i) begin
            rdata_q <= rdata_fmt;
          end else if (wait_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; bus fields are only non-zero while the request is up.
  always_comb begin
    done_o      = (state_q == RESP);
    err_o       = done_o & err_q;
    stall_o     = req_i & ~done_o;
    mem_req_o   = (state_q == ISSUE);
    mem_we_o    = mem_req_o & we_q;
    mem_be_o    = mem_req_o ? be_w : 4'b0000;
    mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wdata_o = mem_req_o ? wdata_w : 32'd0;
    rdata_o     = rdata_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, randomized
// transactions against an arithmetic reference model, and reset sequences.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o, done_o, err_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int nchk = 0;
  int nerr = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .done_o(done_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdin;
    int          gd;       // grant delay in cycles
    int          rd;       // response delay in cycles (>= T means never)
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_err;
    int          e_lat;    // cycles from req sample to done_o
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: expectations from the access rules in plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic illegal;
    int off, sz, hidx;
    logic [31:0] b, h, lv;
    off  = int'(v.addr % 4);
    hidx = int'((v.addr >> 1) % 2);
    sz   = int'(v.f3 % 4);
    illegal = (v.f3 == 3'd3) || (v.f3 == 3'd6) || (v.f3 == 3'd7) || (v.we && v.f3 >= 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 1 && (off % 2) != 0) illegal = 1'b1;
    if (sz == 2 && off != 0) illegal = 1'b1;
`endif
    r.e_addr  = v.addr - 32'(off);
    r.e_be    = 4'hF;
    r.e_wdata = v.wdata;
    if (v.we && sz == 0) begin
      r.e_be    = 4'(1 << off);
      r.e_wdata = (v.wdata % 256) * 32'h01010101;
    end else if (v.we && sz == 1) begin
      r.e_be    = 4'(3 << (2 * hidx));
      r.e_wdata = (v.wdata % 65536) * 32'h00010001;
    end
    b = (v.rdin >> (8 * off)) % 256;
    h = (v.rdin >> (16 * hidx)) % 65536;
    case (v.f3)
      3'd0:    lv = (b >= 128) ? (b + 32'hFFFFFF00) : b;
      3'd4:    lv = b;
      3'd1:    lv = (h >= 32768) ? (h + 32'hFFFF0000) : h;
      3'd5:    lv = h;
      default: lv = v.rdin;
    endcase
    if (illegal) begin
      r.e_err = 1'b1; r.e_lat = 1; r.e_rdata = 0;
    end else if (v.rd >= T) begin
      r.e_err = 1'b1; r.e_lat = 2 + v.gd + T; r.e_rdata = 0;
    end else begin
      r.e_err = 1'b0; r.e_lat = 3 + v.gd + v.rd; r.e_rdata = lv;
    end
    return r;
  endfunction

  // Called just after a rising edge; that cycle is the req sample cycle.
  task automatic run_txn(input vec_t v);
    logic bus;
    bus = (v.e_lat > 1);
    req_i = 1'b1; we_i = v.we; funct3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    for (int c = 1; c <= v.e_lat + 4; c++) begin
      @(posedge clk); #1;
      mem_gnt_i    = bus && (c == 1 + v.gd);
      mem_rvalid_i = bus && !v.e_err && (c == 2 + v.gd + v.rd);
      mem_rdata_i  = mem_rvalid_i ? v.rdin : $urandom;
      @(negedge clk);
      chk("mem_req", mem_req_o, bus && (c <= 1 + v.gd));
      if (mem_req_o) begin
        chk("mem_addr", mem_addr_o, v.e_addr);
        chk("mem_be", mem_be_o, v.e_be);
        chk("mem_we", mem_we_o, v.we);
        if (v.we) chk("mem_wdata", mem_wdata_o, v.e_wdata);
      end
      chk("done", done_o, c == v.e_lat);
      chk("stall", stall_o, c != v.e_lat);
      if (done_o || c == v.e_lat) begin
        chk("err", err_o, v.e_err);
        if (!v.we || v.e_err) chk("rdata", rdata_o, v.e_rdata);
        break;
      end
    end
    @(posedge clk); #1;
    req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    chk("state_idle", dut.state_q, IDLE);
    chk("done_low", done_o, 1'b0);
    if (!v.we || v.e_err) chk("rdata_hold", rdata_o, v.e_rdata);
  endtask

  vec_t vt[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdin, input int gd,
                              input int rd, input logic [31:0] erd, input logic [3:0] ebe,
                              input logic [31:0] ea, input logic [31:0] ewd, input logic eerr,
                              input int elat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdin = rdin; v.gd = gd; v.rd = rd;
    v.e_rdata = erd; v.e_be = ebe; v.e_addr = a & 32'hFFFF_FFFC; v.e_wdata = ewd;
    v.e_err = eerr; v.e_lat = elat;
    if (ea != a) v.e_addr = ea;
    return v;
  endfunction

  initial begin
    vec_t v;
    reset = 1'b0; req_i = 1'b1; we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h0;
    wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #12;
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_be", mem_be_o, 4'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_stall", stall_o, 1'b1);
    chk("rst_state", dut.state_q, IDLE);
    req_i = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: we, f3, addr, wdata, rdin, gd, rd, exp rdata/be/addr/wdata/err/lat
    vt.push_back(mk(1, F3_B,  32'h1003, 32'hAABBCCDD, 0, 0, 0, 0, 4'b1000, 32'h1000, 32'hDDDDDDDD, 0, 3));
    vt.push_back(mk(0, F3_B,  32'h2002, 0, 32'h00800000, 0, 0, 32'hFFFFFF80, 4'hF, 32'h2000, 0, 0, 3));
    vt.push_back(mk(0, F3_BU, 32'h2002, 0, 32'h00800000, 0, 0, 32'h00000080, 4'hF, 32'h2000, 0, 0, 3));
    vt.push_back(mk(0, F3_H,  32'h2002, 0, 32'h80010000, 2, 3, 32'hFFFF8001, 4'hF, 32'h2000, 0, 0, 8));
    vt.push_back(mk(0, F3_W,  32'h4000, 0, 32'h12345678, 0, 99, 32'h0, 4'hF, 32'h4000, 0, 1, 6));
`ifdef LSU_MISALIGN_TRAP_EN
    vt.push_back(mk(1, F3_W,  32'h3002, 32'hCAFEF00D, 0, 0, 0, 32'h0, 4'hF, 32'h3000, 32'hCAFEF00D, 1, 1));
`else
    vt.push_back(mk(1, F3_W,  32'h3002, 32'hCAFEF00D, 0, 0, 0, 32'h0, 4'hF, 32'h3000, 32'hCAFEF00D, 0, 3));
`endif
    vt.push_back(mk(0, 3'b011, 32'h5000, 0, 0, 0, 0, 32'h0, 4'hF, 32'h5000, 0, 1, 1));
    vt.push_back(mk(1, F3_H,  32'h1002, 32'h1234ABCD, 0, 1, 0, 0, 4'b1100, 32'h1000, 32'hABCDABCD, 0, 4));
    vt.push_back(mk(1, F3_BU, 32'h1000, 32'h11223344, 0, 0, 0, 32'h0, 4'hF, 32'h1000, 0, 1, 1));
    vt.push_back(mk(0, F3_HU, 32'h2000, 0, 32'h1234F00D, 0, 1, 32'h0000F00D, 4'hF, 32'h2000, 0, 0, 4));
    vt.push_back(mk(0, F3_W,  32'h6004, 0, 32'hDEADBEEF, 0, T-1, 32'hDEADBEEF, 4'hF, 32'h6004, 0, 0, 3+T-1));
    vt.push_back(mk(0, F3_W,  32'h6008, 0, 32'h0, 1, 99, 32'h0, 4'hF, 32'h6008, 0, 1, 3+T));
    vt.push_back(mk(1, F3_B,  32'h7001, 32'h000000A5, 0, 0, 2, 0, 4'b0010, 32'h7000, 32'hA5A5A5A5, 0, 5));
    for (int i = 0; i < vt.size(); i++) run_txn(vt[i]);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.f3    = 3'($urandom_range(0, 7));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.rdin  = $urandom;
      v.gd    = $urandom_range(0, 3);
      v.rd    = $urandom_range(0, T + 1);
      run_txn(model(v));
    end

    // Reset while in ISSUE: request must drop without waiting for a clock.
    req_i = 1'b1; we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h8000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("issue_req_up", mem_req_o, 1'b1);
    #1 reset = 1'b0;
    #1 chk("async_req_drop", mem_req_o, 1'b0);
    chk("rst_issue_state", dut.state_q, IDLE);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Reset while in WAIT, then a late response that must be ignored.
    req_i = 1'b1;
    @(posedge clk); #1 mem_gnt_i = 1'b1;
    @(posedge clk); #1 mem_gnt_i = 1'b0;
    chk("in_wait", dut.state_q, WAIT);
    #1 reset = 1'b0;
    #1 chk("rst_wait_req", mem_req_o, 1'b0);
    chk("rst_wait_done", done_o, 1'b0);
    chk("rst_wait_state", dut.state_q, IDLE);
    req_i = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("late_rvalid_done", done_o, 1'b0);
      chk("late_rvalid_req", mem_req_o, 1'b0);
      chk("late_rvalid_state", dut.state_q, IDLE);
    end
    mem_rvalid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store unit between the RV32I datapath's memory port (ALUResult, WriteData, funct3) and a request/grant/response data-memory bus. It turns one core load or store into a single word-aligned bus transaction with byte enables. It stalls the core until the transaction completes, then returns sign- or zero-extended load data as ReadData. It also flags illegal or timed-out accesses.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT for mem_rvalid_i before aborting; legal range 2..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  1  core access request; held high by the core until done_o.
- we_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  width/sign code, Instr[14:12].
- addr_i  in  32  byte address (ALUResult).
- wdata_i  in  32  store data (WriteData).
- rdata_o  out  32  formatted load data to the datapath ReadData.
- stall_o  out  1  core must hold the PC and hold its request.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse with done_o: illegal funct3, misaligned access, or timeout.
- mem_req_o  out  1  bus request.
- mem_gnt_i  in  1  bus grant.
- mem_we_o  out  1  bus write.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  32  word address, bits [1:0] = 0.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rvalid_i  in  1  response valid; acknowledges loads and stores.
- mem_rdata_i  in  32  load response word.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, req_i=1, legal access:
  - capture addr_i, we_i, funct3_i and wdata_i into registers.
  - go to ISSUE.
- IDLE, req_i=1, illegal access (funct3 011, 110, 111; stores with funct3[2]=1; misaligned, see Configuration):
  - go directly to RESP with the error flag set.
  - no bus activity.
- ISSUE:
  - drive mem_req_o=1 and all mem_* outputs from the captured registers.
  - stay in ISSUE until mem_gnt_i=1, then go to WAIT.
  - mem_rvalid_i is ignored while in ISSUE.
- WAIT:
  - timeout counter starts at 0 on entry and increments each cycle.
  - mem_rvalid_i=1: capture the formatted data, go to RESP.
  - no mem_rvalid_i by count TIMEOUT_CYCLES-1: go to RESP with the error flag set, rdata = 0.
- RESP:
  - done_o=1; err_o = error flag.
  - go unconditionally to IDLE.
- stall_o = req_i & ~done_o, combinational.
- rdata_o is registered:
  - updated only on entry to RESP.
  - forced to 0 on error.
  - holds its value until the next completion.
- Lanes and enables (o = addr[1:0]):
  - SB: be = 4'b0001<<o; wdata = byte replicated ×4.
  - SH: be = 4'b0011<<(2·addr[1]); wdata = halfword replicated ×2.
  - SW: be = 4'b1111.
- Load formatting:
  - LB/LBU select byte o; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes the word through.
- Loads drive mem_be_o = 4'b1111.
- Reset mid-operation: all state returns to IDLE immediately and mem_req_o drops asynchronously. A late mem_rvalid_i arriving in IDLE is ignored.

## Timing
- Reset values: state IDLE, rdata_o 0, and done_o, err_o, mem_req_o, mem_we_o all 0. mem_be_o, mem_addr_o and mem_wdata_o are 0. stall_o = req_i.
- Zero-wait-state bus:
  - cycle 0: req_i sampled in IDLE.
  - cycle 1: ISSUE, mem_gnt_i=1.
  - cycle 2: WAIT, mem_rvalid_i=1.
  - cycle 3: RESP, done_o=1.
  - Total 3 cycles from request to done.
- Each grant wait or response wait cycle adds 1.
- Illegal access: done_o=1 and err_o=1 in cycle 1.
- Timeout: done_o=1 in cycle 2 + TIMEOUT_CYCLES after grant, counted from the ISSUE grant cycle.
- Back-to-back accesses: the core advances on the done_o edge. The next req_i is sampled in IDLE the cycle after RESP, giving 1 idle cycle between transactions.
- Bus outputs are registered-stable for the whole ISSUE state.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: an access is misaligned when it is a halfword with addr[0]=1 or a word with addr[1:0]≠0. A misaligned access follows the illegal-access path: err_o pulses and no bus request is issued.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalignment is never an error; halfword accesses treat addr[0] as 0 and word accesses treat addr[1:0] as 0.
  - the access proceeds on the bus normally.
  - err_o can then only come from an illegal funct3 or a timeout.

## Structure
- Package lsu_pkg holds:
  - state enum lsu_state_t (IDLE, ISSUE, WAIT, RESP).
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- Sub-module lsu_align, purely combinational, computes:
  - mem_be_o and mem_wdata_o from the captured store request.
  - the formatted load word from mem_rdata_i.
- The FSM, timeout counter and capture registers live in lsu_ctrl.

## Test plan
- SB, addr 0x1003, wdata 0xAABBCCDD, zero-wait bus: mem_addr_o 0x1000, mem_be_o 4'b1000, mem_wdata_o 0xDDDDDDDD; done_o 3 cycles after req_i; err_o 0.
- LB, addr 0x2002, mem_rdata_i 0x00800000: rdata_o 0xFFFFFF80. The same access as LBU: rdata_o 0x00000080.
- LH, addr 0x2002, mem_gnt_i delayed 2 cycles and mem_rvalid_i delayed 3: mem_rdata_i 0x80010000 gives rdata_o 0xFFFF8001; stall_o held high for all 8 cycles until done_o.
- LW with mem_rvalid_i never asserted and TIMEOUT_CYCLES=4: err_o and done_o pulse together, rdata_o 0, FSM back in IDLE.
- SW, addr 0x3002, with LSU_MISALIGN_TRAP_EN: err_o in cycle 1 and mem_req_o never asserted. Without the macro: mem_addr_o 0x3000, mem_be_o 4'b1111.
- Reset asserted while in WAIT, then mem_rvalid_i=1 after release: mem_req_o is 0 immediately, done_o is never pulsed, state is IDLE.
